mux8_rr_arbiter: RTL and testbench
==================================

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 4, maximum consecutive GRANT cycles per grant (legal range 1..15).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port req, input, [7:0]: bit i is the request from requester i.
REQ-005 The block SHALL have the port d, input, [0:7]: d[i] is the data bit of requester i.
REQ-006 The block SHALL have the port gnt, output, [7:0]: one-hot grant, registered.
REQ-007 The block SHALL have the port s, output, [2:0]: encoded index of the granted requester, which drives the shared 8:1 select, registered.
REQ-008 The block SHALL have the port y, output, 1 bit: registered sample of the selected data bit.
REQ-009 The block SHALL have the port y_vld, output, 1 bit: y holds a valid sample, registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-011 Arbitration SHALL be round-robin: search begins at ptr+1 (mod 8), ascending with wrap 7->0, and the first set req bit wins.
REQ-012 ptr (3 bits) SHALL load the winner index on every entry to GRANT.
REQ-013 IDLE: if req != 0, next state SHALL be GRANT with gnt = one-hot(winner), s = winner, hold_cnt = 0; else stay IDLE.
REQ-014 GRANT: hold_cnt SHALL increment each cycle, saturating at 15.
REQ-015 GRANT SHALL exit to RELEASE when req[s] is sampled 0, or when hold_cnt == HOLD_MAX-1 (whichever comes first).
REQ-016 The result of REQ-015 SHALL be at most HOLD_MAX GRANT cycles per grant.
REQ-017 RELEASE SHALL last exactly one cycle with gnt = 0 and s held at its last value (dead cycle so the select switches cleanly).
REQ-018 From RELEASE, if req != 0, the block SHALL go directly to GRANT with a new winner per REQ-011; else IDLE.
REQ-019 gnt SHALL be nonzero only in GRANT and never have more than one bit set.
REQ-020 y SHALL be updated each cycle: y <= d[s] if the current state is GRANT, else 0.
REQ-021 y_vld SHALL be set each cycle: y_vld <= (current state == GRANT), i.e. 1-cycle lag behind gnt.
REQ-022 A requester whose req remains high after a HOLD_MAX expiry SHALL be re-granted only after all other pending requesters have been served once.
REQ-023 A sole requester SHALL be re-granted every HOLD_MAX+1 cycles (HOLD_MAX GRANT + 1 RELEASE).
REQ-024 If req[s] falls and rises again within GRANT, the fall SHALL still end the grant.
REQ-025 Changes on req bits other than s during GRANT SHALL have no effect until the next arbitration.
REQ-026 d SHALL NOT affect the FSM.

Reset
REQ-027 While rst_n = 0 (asynchronous, regardless of clk): state = IDLE, gnt = 0, s = 0, y = 0, y_vld = 0, hold_cnt = 0, ptr = 7 (so the first search starts at requester 0).
REQ-028 Reset asserted mid-GRANT SHALL drop gnt within the same cycle without waiting for a clock edge; after rst_n deasserts, the first grant SHALL follow REQ-013.

Verification
REQ-029 Bench SHALL cover async reset: rst_n pulsed low mid-clock during GRANT of requester 5 -> gnt = 0, s = 0, y = 0, y_vld = 0 before the next edge; after release with req = 8'h20 -> gnt = 8'h20 one cycle later.
REQ-030 Bench SHALL cover the sole requester at HOLD_MAX = 4: req = 8'h08 held -> gnt = 8'h08, s = 3 for 4 cycles, 0 for 1 cycle, repeat with period 5.
REQ-031 Bench SHALL cover full load: req = 8'hFF held from reset -> grant order 0,1,2,...,7,0, each 4 cycles followed by a 1-cycle gap.
REQ-032 Bench SHALL cover early release: req = 8'h64, requester 5 granted, req[5] dropped after 2 GRANT cycles -> RELEASE next cycle, then grant to 6 (not 2), then 2.
REQ-033 Bench SHALL cover the data path: requester 2 granted, d[2] toggling every cycle -> y equals d[2] of the previous cycle with y_vld = 1 during the grant, and y = 0, y_vld = 0 one cycle after the grant ends.
REQ-034 Bench SHALL cover the idle case: req = 0 for 20 cycles -> state IDLE, gnt = 0, y_vld = 0 throughout.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter for eight requesters that share one 8:1 data select.
//
// A grant lasts at most HOLD_MAX cycles. It ends early when the owner drops
// its request. Every grant is followed by a one-cycle RELEASE gap with gnt
// low, so the shared select never switches while a grant is active. The
// selected data bit is registered into y. y_vld marks each cycle in which y
// carries a sample taken during GRANT.
//
// Parameters
//   HOLD_MAX  maximum consecutive GRANT cycles per grant (1..15), default 4
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   req[7:0]  request vector, bit i = requester i
//   d[0:7]    data bits, d[i] belongs to requester i
//   gnt[7:0]  registered one-hot grant (all zero outside GRANT)
//   s[2:0]    registered index of the current/last owner (select of the mux)
//   y         registered sample of d[s], taken while in GRANT, else 0
//   y_vld     registered flag: y holds a sample taken during GRANT
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [0:7] d,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       y,
  output logic       y_vld
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Value of hold_cnt during the final allowed GRANT cycle. hold_cnt is 0 in
  // the first GRANT cycle.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_e     state_q,    state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] ptr_q,      ptr_d;
  logic [7:0] gnt_q,      gnt_d;
  logic [2:0] s_q,        s_d;
  logic       y_q,        y_d;
  logic       y_vld_q,    y_vld_d;

  logic       req_any;
  logic       start_grant;
  logic [2:0] win_idx;
  logic       win_found;
  logic [2:0] cand;

  assign req_any = |req;

  // -------------------------------------------------------------------------
  // Round-robin winner search.
  // The search starts one past the last winner and wraps from 7 to 0. The
  // first set request bit wins. At k = 8 the candidate wraps back to ptr_q
  // itself, so the last owner is chosen only when nobody else is requesting.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first. A path that
    // leaves a variable unassigned would infer a latch.
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A new arbitration happens from IDLE or RELEASE when any request is set.
  assign start_grant = (state_q != GRANT) && req_any;

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    s_d        = s_q;

    unique case (state_q)
      IDLE, RELEASE: begin
        if (start_grant) begin
          state_d    = GRANT;
          gnt_d      = 8'b1 << win_idx;
          s_d        = win_idx;
          ptr_d      = win_idx;
          hold_cnt_d = 4'd0;
        end else begin
          // RELEASE always lasts exactly one cycle. s keeps its last value.
          state_d = IDLE;
          gnt_d   = 8'h00;
        end
      end

      GRANT: begin
        if (hold_cnt_q != 4'hF) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
        // The owner's request is sampled every cycle. A single low cycle ends
        // the grant, even if the request rises again afterwards. Requests from
        // the other requesters are ignored until the next arbitration.
        if (!req[s_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d = RELEASE;
          gnt_d   = 8'h00;
        end
      end

      default: begin
        state_d    = IDLE;
        gnt_d      = 8'h00;
        hold_cnt_d = 4'd0;
      end
    endcase
  end

  // Data path: sample the selected bit only while a grant is active. d feeds
  // only y and never affects the FSM.
  always_comb begin
    y_vld_d = (state_q == GRANT);
    y_d     = (state_q == GRANT) ? d[s_q] : 1'b0;
  end

  // -------------------------------------------------------------------------
  // State registers. The reset is asynchronous, so gnt drops as soon as
  // rst_n falls, without waiting for a clock edge. ptr resets to 7 so the
  // first search after reset starts at requester 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= 4'd0;
      ptr_q      <= 3'd7;
      gnt_q      <= 8'h00;
      s_q        <= 3'd0;
      y_q        <= 1'b0;
      y_vld_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then updates from the values present before the edge.
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      s_q        <= s_d;
      y_q        <= y_d;
      y_vld_q    <= y_vld_d;
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign y     = y_q;
  assign y_vld = y_vld_q;

  // -------------------------------------------------------------------------
  // Structural invariants of the grant outputs.
  // -------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));

  a_gnt_only_in_grant : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q != 8'h00) == (state_q == GRANT));

  a_gnt_matches_s : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_q != 8'h00) |-> (gnt_q == (8'b1 << s_q)));

  a_hold_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GRANT) |-> (hold_cnt_q <= HOLD_LAST));

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [0:7] d;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       y;
  logic       y_vld;

  int n_checks = 0;
  int n_fail   = 0;

  mux8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .s     (s),
    .y     (y),
    .y_vld (y_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model. It tracks the phase, the owner, the round-robin
  // pointer and how many GRANT cycles the owner has used so far.
  // ---------------------------------------------------------------------
  localparam int P_IDLE = 0, P_GRANT = 1, P_REL = 2;
  int         m_phase;
  int         m_owner;
  int         m_ptr;
  int         m_used;
  logic [7:0] m_gnt;
  logic [2:0] m_s;
  logic       m_y;
  logic       m_vld;

  task automatic model_reset();
    m_phase = P_IDLE; m_owner = 0; m_ptr = 7; m_used = 0;
    m_gnt = 8'h00; m_s = 3'd0; m_y = 1'b0; m_vld = 1'b0;
  endtask

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return p;
  endfunction

  // Called right after a rising edge. req and d still hold the values that
  // the design sampled on that edge.
  task automatic model_step();
    m_vld = (m_phase == P_GRANT);
    m_y   = (m_phase == P_GRANT) ? d[m_owner] : 1'b0;
    if (m_phase == P_GRANT) begin
      if (!req[m_owner] || m_used >= HOLD) m_phase = P_REL;
      else m_used++;
    end else if (req != 8'h00) begin
      m_owner = rr_pick(req, m_ptr);
      m_ptr   = m_owner;
      m_used  = 1;
      m_phase = P_GRANT;
    end else begin
      m_phase = P_IDLE;
    end
    m_gnt = (m_phase == P_GRANT) ? (8'h01 << m_owner) : 8'h00;
    m_s   = 3'(m_owner);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    d     = 8'h00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic [0:7] d;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       y;
    logic       vld;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [0:7] da;
    logic [0:7] db;
    logic       d2;
    int         order;

    rst_n = 1'b0;
    req   = 8'h00;
    d     = 8'h00;
    model_reset();

    // -------- table: sole requester 3, then early release 5 -> 6 -> 2 ----
    da = 8'b0001_0000;   // d[3] = 1
    db = 8'b0010_0100;   // d[2] = 1, d[5] = 1, d[6] = 0
    tbl[0]  = '{8'h08, da, 8'h08, 3'd3, 1'b0, 1'b0};
    tbl[1]  = '{8'h08, da, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[2]  = '{8'h08, da, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[3]  = '{8'h08, da, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[4]  = '{8'h08, da, 8'h00, 3'd3, 1'b1, 1'b1};
    tbl[5]  = '{8'h64, db, 8'h20, 3'd5, 1'b0, 1'b0};
    tbl[6]  = '{8'h64, db, 8'h20, 3'd5, 1'b1, 1'b1};
    tbl[7]  = '{8'h44, db, 8'h00, 3'd5, 1'b1, 1'b1};
    tbl[8]  = '{8'h44, db, 8'h40, 3'd6, 1'b0, 1'b0};
    tbl[9]  = '{8'h44, db, 8'h40, 3'd6, 1'b0, 1'b1};
    tbl[10] = '{8'h04, db, 8'h00, 3'd6, 1'b0, 1'b1};
    tbl[11] = '{8'h04, db, 8'h04, 3'd2, 1'b0, 1'b0};
    tbl[12] = '{8'h00, db, 8'h00, 3'd2, 1'b1, 1'b1};
    tbl[13] = '{8'h00, db, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[14] = '{8'h00, db, 8'h00, 3'd2, 1'b0, 1'b0};

    // Reset state, checked while rst_n is still low.
    #12;
    check("rst_gnt", gnt, 8'h00);
    check("rst_s", s, 3'd0);
    check("rst_y", y, 1'b0);
    check("rst_vld", y_vld, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req;
      d   = tbl[i].d;
      step();
      check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      check($sformatf("tbl%0d_s", i), s, tbl[i].s);
      check($sformatf("tbl%0d_y", i), y, tbl[i].y);
      check($sformatf("tbl%0d_vld", i), y_vld, tbl[i].vld);
    end

    // -------- sole requester 3: period HOLD+1 -----------------------------
    do_reset();
    req = 8'h08;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < HOLD; c++) begin
        step();
        check("sole_gnt", gnt, 8'h08);
        check("sole_s", s, 3'd3);
      end
      step();
      check("sole_gap_gnt", gnt, 8'h00);
      check("sole_gap_s", s, 3'd3);
    end

    // -------- full load: order 0..7,0, each HOLD cycles + 1 gap -----------
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      order = g % 8;
      for (int c = 0; c < HOLD; c++) begin
        step();
        check($sformatf("full%0d_gnt", g), gnt, 8'h01 << order);
        check($sformatf("full%0d_s", g), s, order);
      end
      step();
      check($sformatf("full%0d_gap", g), gnt, 8'h00);
    end

    // -------- data path: requester 2, d[2] toggles every cycle ------------
    do_reset();
    req = 8'h04;
    step();
    check("dp_first_gnt", gnt, 8'h04);
    check("dp_first_vld", y_vld, 1'b0);
    for (int c = 0; c < HOLD; c++) begin
      d2   = c[0] ^ 1'b1;
      d    = 8'h00;
      d[2] = d2;
      if (c == HOLD - 1) req = 8'h00;
      step();
      check("dp_y", y, d2);
      check("dp_vld", y_vld, 1'b1);
    end
    d = 8'hFF;
    step();
    check("dp_end_y", y, 1'b0);
    check("dp_end_vld", y_vld, 1'b0);

    // -------- idle: no requests for 20 cycles -----------------------------
    do_reset();
    for (int c = 0; c < 20; c++) begin
      d = 8'($urandom);
      step();
      check("idle_gnt", gnt, 8'h00);
      check("idle_vld", y_vld, 1'b0);
      check("idle_y", y, 1'b0);
    end

    // -------- async reset during GRANT of requester 5 ---------------------
    do_reset();
    req = 8'h20;
    d   = 8'b0000_0100;   // d[5] = 1
    step(); step(); step();
    check("ar_pre_gnt", gnt, 8'h20);
    check("ar_pre_y", y, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt", gnt, 8'h00);
    check("ar_s", s, 3'd0);
    check("ar_y", y, 1'b0);
    check("ar_vld", y_vld, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    check("ar_regrant_gnt", gnt, 8'h20);
    check("ar_regrant_s", s, 3'd5);

    // -------- randomized traffic against the reference model --------------
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: req = 8'h00;
          1: req = 8'h01 << $urandom_range(7);
          2: req = 8'($urandom);
          default: req = req ^ (8'h01 << $urandom_range(7));
        endcase
      end
      d = 8'($urandom);
      step();
      check("rnd_gnt", gnt, m_gnt);
      check("rnd_s", s, m_s);
      check("rnd_y", y, m_y);
      check("rnd_vld", y_vld, m_vld);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
